// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular multiplier.
//   state_t : controller state encoding (IDLE, CHECK, RUN, DONE)
//   clog2   : ceil(log2(value)), used to size the bit counter
package rsa_pkg;

   // Three bits leave spare codes. The controller maps every spare code back to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rsa_modmult_step.sv
// One combinational iteration of the MSB-first shift-and-add multiplier.
// Ports:
//   mode   : 0 = plain product, 1 = modular product
//   b_bit  : current multiplier bit (MSB first)
//   p      : accumulator before this step (2W bits)
//   a      : multiplicand
//   n      : modulus (used only in mode 1)
//   p_next : accumulator after this step (2W bits)
module rsa_modmult_step #(
   parameter int W = 8
) (
   input  logic           mode,
   input  logic           b_bit,
   input  logic [2*W-1:0] p,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   n,
   output logic [2*W-1:0] p_next
);

   logic [2*W-1:0] plain_sum;
   logic [W+1:0]   a_ext;
   logic [W+1:0]   n_ext;
   logic [W+1:0]   t;
   logic [W+1:0]   t1;
   logic [W+1:0]   t2;

   // In mode 1 the incoming P is below N, so 2P + A is below 3N.
   // That value fits in W+2 bits, and two conditional subtractions bring it back below N.
   always_comb begin
      a_ext     = (W+2)'(a);
      n_ext     = (W+2)'(n);
      plain_sum = (p << 1) + (b_bit ? (2*W)'(a) : '0);
      t         = ((W+2)'(p[W-1:0]) << 1) + (b_bit ? a_ext : '0);
      t1        = (t >= n_ext) ? (t - n_ext) : t;
      t2        = (t1 >= n_ext) ? (t1 - n_ext) : t1;
      p_next    = mode ? (2*W)'(t2) : plain_sum;
   end

endmodule

// File: rtl/rsa_core_modmult.sv
// Sequential multiplier that computes either a*b or (a*b) mod n.
// It processes one bit of b per clock cycle.
// Ports:
//   mmul_clk   : clock. The active edge is selected by CLK_EDGE.
//   mmul_rst   : asynchronous active-low reset
//   mmul_start : operation request, active at level START, sampled in IDLE
//   mmul_mode  : 0 = a*b, 1 = (a*b) mod n
//   mmul_a/b/n : operands (W bits each)
//   mmul_busy  : operation in progress
//   mmul_done  : one-cycle completion pulse
//   mmul_err   : the last modular operation had illegal operands
//   mmul_c     : result (2W bits), held until the next completion
module rsa_core_modmult
   import rsa_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_EDGE   = 1,
   parameter int START      = 1
) (
   input  logic                    mmul_clk,
   input  logic                    mmul_rst,
   input  logic                    mmul_start,
   input  logic                    mmul_mode,
   input  logic [DATA_WIDTH-1:0]   mmul_a,
   input  logic [DATA_WIDTH-1:0]   mmul_b,
   input  logic [DATA_WIDTH-1:0]   mmul_n,
   output logic                    mmul_busy,
   output logic                    mmul_done,
   output logic                    mmul_err,
   output logic [2*DATA_WIDTH-1:0] mmul_c
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   n_q;
   logic           mode_q;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_next;
   logic [CW-1:0]  cnt;
   logic           err_pend;
   logic           operand_bad;
   logic           start_req;
   logic           clk_act;

   // For the falling-edge variant the clock is inverted.
   // All flops then act on a rising edge of clk_act.
   assign clk_act     = (CLK_EDGE != 0) ? mmul_clk : ~mmul_clk;
   assign start_req   = (mmul_start == (START != 0));
   assign operand_bad = mode_q && ((n_q == '0) || (a_q >= n_q) || (b_q >= n_q));

   // b_q shifts left during RUN, so its MSB is always the current multiplier bit.
   rsa_modmult_step #(.W(W)) u_step (
      .mode   (mode_q),
      .b_bit  (b_q[W-1]),
      .p      (acc),
      .a      (a_q),
      .n      (n_q),
      .p_next (acc_next)
   );

   always_ff @(posedge clk_act or negedge mmul_rst) begin
      if (!mmul_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start_req) state_next = ST_CHECK;
         ST_CHECK: state_next = operand_bad ? ST_DONE : ST_RUN;
         ST_RUN:   if (cnt == LAST) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // The done pulse is cleared on the first IDLE cycle after DONE.
   // A start seen in that same cycle is still accepted, so operations can run back to back.
   always_ff @(posedge clk_act or negedge mmul_rst) begin
      if (!mmul_rst) begin
         a_q       <= '0;
         b_q       <= '0;
         n_q       <= '0;
         mode_q    <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         err_pend  <= 1'b0;
         mmul_busy <= 1'b0;
         mmul_done <= 1'b0;
         mmul_err  <= 1'b0;
         mmul_c    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               mmul_done <= 1'b0;
               if (start_req) begin
                  a_q       <= mmul_a;
                  b_q       <= mmul_b;
                  n_q       <= mmul_n;
                  mode_q    <= mmul_mode;
                  acc       <= '0;
                  cnt       <= '0;
                  err_pend  <= 1'b0;
                  mmul_busy <= 1'b1;
               end
            end
            ST_CHECK: begin
               err_pend <= operand_bad;
            end
            ST_RUN: begin
               acc <= acc_next;
               b_q <= b_q << 1;
               cnt <= cnt + CW'(1);
            end
            ST_DONE: begin
               mmul_c    <= err_pend ? '0 : acc;
               mmul_err  <= err_pend;
               mmul_done <= 1'b1;
               mmul_busy <= 1'b0;
            end
            default: begin
               mmul_done <= 1'b0;
               mmul_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_core_modmult.sv
// Self-checking bench for rsa_core_modmult.
// DUTs: 8-bit rising edge, 8-bit falling edge (driven by an inverted clock), 32-bit rising edge.
module tb_rsa_core_modmult;

   localparam int W8  = 8;
   localparam int W32 = 32;

   logic clk = 1'b0;
   logic clk_inv;
   logic rst;

   logic        start8, mode8;
   logic [7:0]  a8, b8, n8;
   logic        busy8, done8, err8;
   logic [15:0] c8;
   logic        busyf, donef, errf;
   logic [15:0] cf;

   logic        start32, mode32;
   logic [31:0] a32, b32, n32;
   logic        busy32, done32, err32;
   logic [63:0] c32;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        mode;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  n;
      logic [15:0] exp_c;
      logic        exp_err;
   } vec_t;

   vec_t vecs [10];

   always #5 clk = ~clk;
   assign clk_inv = ~clk;

   rsa_core_modmult #(.DATA_WIDTH(W8), .CLK_EDGE(1), .START(1)) dut8 (
      .mmul_clk(clk), .mmul_rst(rst), .mmul_start(start8), .mmul_mode(mode8),
      .mmul_a(a8), .mmul_b(b8), .mmul_n(n8),
      .mmul_busy(busy8), .mmul_done(done8), .mmul_err(err8), .mmul_c(c8));

   rsa_core_modmult #(.DATA_WIDTH(W8), .CLK_EDGE(0), .START(1)) dut8f (
      .mmul_clk(clk_inv), .mmul_rst(rst), .mmul_start(start8), .mmul_mode(mode8),
      .mmul_a(a8), .mmul_b(b8), .mmul_n(n8),
      .mmul_busy(busyf), .mmul_done(donef), .mmul_err(errf), .mmul_c(cf));

   rsa_core_modmult #(.DATA_WIDTH(W32), .CLK_EDGE(1), .START(1)) dut32 (
      .mmul_clk(clk), .mmul_rst(rst), .mmul_start(start32), .mmul_mode(mode32),
      .mmul_a(a32), .mmul_b(b32), .mmul_n(n32),
      .mmul_busy(busy32), .mmul_done(done32), .mmul_err(err32), .mmul_c(c32));

   // Reference model: a direct arithmetic statement of what the result must be.
   function automatic void model(input logic mode, input longint unsigned a, input longint unsigned b,
                                 input longint unsigned n, output longint unsigned c, output logic err);
      err = mode && ((n == 0) || (a >= n) || (b >= n));
      if (err)       c = 0;
      else if (mode) c = (a * b) % n;
      else           c = a * b;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives the operands with start high, lets edge 0 sample them, then drops start.
   task automatic applyStimulus(input logic mode, input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
      mode8 = mode; a8 = a; b8 = b; n8 = n; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic applyStimulus32(input logic mode, input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
      mode32 = mode; a32 = a; b32 = b; n32 = n; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
   endtask

   // Waits a bounded number of edges for done on both 8-bit DUTs.
   // Then checks latency, result, error flag, busy behaviour and the pulse width.
   task automatic waitDone8(input string name, input int lat, input logic [15:0] ec, input logic ee);
      int kd = -1;
      int kf = -1;
      int busy_bad = 0;
      logic [15:0] cd = '0;
      logic [15:0] cfv = '0;
      logic ed = 1'b0;
      logic ef = 1'b0;
      for (int k = 1; k <= lat + 4; k++) begin
         @(posedge clk); #1;
         if (kd < 0 && done8) begin
            kd = k; cd = c8; ed = err8;
            checkOutput({name, "_busy_at_done"}, 64'(busy8), 64'(0));
         end else if (kd < 0 && !busy8) begin
            busy_bad++;
         end
         if (kf < 0 && donef) begin
            kf = k; cfv = cf; ef = errf;
         end
         if (kd >= 0 && kf >= 0) break;
      end
      checkOutput({name, "_latency"},     64'(kd), 64'(lat));
      checkOutput({name, "_latency_neg"}, 64'(kf), 64'(lat));
      checkOutput({name, "_c"},           64'(cd), 64'(ec));
      checkOutput({name, "_err"},         64'(ed), 64'(ee));
      checkOutput({name, "_c_neg"},       64'(cfv), 64'(ec));
      checkOutput({name, "_err_neg"},     64'(ef), 64'(ee));
      checkOutput({name, "_busy_gap"},    64'(busy_bad), 64'(0));
      @(posedge clk); #1;
      checkOutput({name, "_pulse"},       64'({done8, donef}), 64'(0));
   endtask

   task automatic waitDone32(input string name, input int lat, input logic [63:0] ec, input logic ee);
      int kd = -1;
      logic [63:0] cd = '0;
      logic ed = 1'b0;
      for (int k = 1; k <= lat + 4; k++) begin
         @(posedge clk); #1;
         if (done32) begin
            kd = k; cd = c32; ed = err32;
            break;
         end
      end
      checkOutput({name, "_latency"}, 64'(kd), 64'(lat));
      checkOutput({name, "_c"},       cd, ec);
      checkOutput({name, "_err"},     64'(ed), 64'(ee));
      @(posedge clk); #1;
      checkOutput({name, "_pulse"},   64'(done32), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      longint unsigned ec;
      logic            ee;
      logic [7:0]      ra, rb, rn;
      logic [31:0]     wa, wb, wn;
      logic            rm;
      int              seen;
      int              kd;

      vecs[0] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 1'b0};
      vecs[1] = '{1'b0, 8'h80, 8'h02, 8'h00, 16'h0100, 1'b0};
      vecs[2] = '{1'b1, 8'h35, 8'h7A, 8'hC5, 16'h00A2, 1'b0};
      vecs[3] = '{1'b1, 8'hFE, 8'hFE, 8'hFF, 16'h0001, 1'b0};
      vecs[4] = '{1'b1, 8'h35, 8'h00, 8'hC5, 16'h0000, 1'b0};
      vecs[5] = '{1'b1, 8'hC4, 8'hC4, 8'hC5, 16'h0001, 1'b0};
      vecs[6] = '{1'b1, 8'h01, 8'h01, 8'h00, 16'h0000, 1'b1};
      vecs[7] = '{1'b1, 8'hC5, 8'h01, 8'hC5, 16'h0000, 1'b1};
      vecs[8] = '{1'b1, 8'h01, 8'hC5, 8'hC5, 16'h0000, 1'b1};
      vecs[9] = '{1'b0, 8'h02, 8'h03, 8'h00, 16'h0006, 1'b0};

      rst = 1'b0;
      start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0; n8 = '0;
      start32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0; n32 = '0;

      #12;
      checkOutput("reset_ctrl8",  64'({busy8, done8, err8}), 64'(0));
      checkOutput("reset_c8",     64'(c8), 64'(0));
      checkOutput("reset_ctrlf",  64'({busyf, donef, errf}), 64'(0));
      checkOutput("reset_cf",     64'(cf), 64'(0));
      checkOutput("reset_ctrl32", 64'({busy32, done32, err32}), 64'(0));
      checkOutput("reset_c32",    c32, 64'(0));
      #2 rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].n);
         waitDone8($sformatf("vec%0d", i), vecs[i].exp_err ? 2 : W8 + 2, vecs[i].exp_c, vecs[i].exp_err);
      end

      // Reset in the middle of RUN. c holds 6 from the last vector, so clearing it is observable.
      applyStimulus(1'b0, 8'hFF, 8'hFF, 8'h00);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("midrun_busy", 64'({busy8, busyf}), 64'(2'b11));
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_async_ctrl", 64'({busy8, done8, err8, busyf, donef, errf}), 64'(0));
      checkOutput("rst_async_c",    64'({c8, cf}), 64'(0));
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done8 || donef) seen++;
      end
      checkOutput("rst_no_done", 64'(seen), 64'(0));
      #3 rst = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b1, 8'h35, 8'h7A, 8'hC5);
      waitDone8("after_reset", W8 + 2, 16'h00A2, 1'b0);

      // Start and operands keep changing while busy. Start stays high through the done cycle.
      mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34; n8 = 8'h00; start8 = 1'b1;
      @(posedge clk); #1;
      seen = 0;
      for (int k = 1; k <= 9; k++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom); mode8 = 1'($urandom);
         start8 = 1'b1;
         @(posedge clk); #1;
         if (done8 || donef || !busy8 || !busyf) seen++;
      end
      checkOutput("b2b_ignore_start", 64'(seen), 64'(0));
      mode8 = 1'b1; a8 = 8'hFE; b8 = 8'hFE; n8 = 8'hFF; start8 = 1'b1;
      @(posedge clk); #1;
      checkOutput("b2b_first_done", 64'({done8, donef}), 64'(2'b11));
      checkOutput("b2b_first_c",    64'({c8, cf}), 64'({16'h03A8, 16'h03A8}));
      @(posedge clk); #1;
      start8 = 1'b0;
      checkOutput("b2b_second_accept", 64'({done8, busy8, busyf}), 64'(3'b011));
      kd = -1;
      for (int k = 12; k <= 25; k++) begin
         @(posedge clk); #1;
         if (done8) begin
            kd = k;
            break;
         end
      end
      checkOutput("b2b_second_latency", 64'(kd), 64'(21));
      checkOutput("b2b_second_c",       64'({c8, cf, 7'd0, err8}), 64'({16'h0001, 16'h0001, 8'h00}));
      @(posedge clk); #1;

      // Random 8-bit operations, mostly with legal modular operands.
      for (int i = 0; i < 40; i++) begin
         rm = 1'($urandom);
         ra = 8'($urandom); rb = 8'($urandom); rn = 8'($urandom);
         if (rm && rn != 0 && $urandom_range(0, 7) != 0) begin
            ra = ra % rn; rb = rb % rn;
         end
         model(rm, 64'(ra), 64'(rb), 64'(rn), ec, ee);
         applyStimulus(rm, ra, rb, rn);
         waitDone8($sformatf("rnd8_%0d", i), ee ? 2 : W8 + 2, 16'(ec), ee);
      end

      // Fixed 32-bit cases, including an error followed by a plain product.
      applyStimulus32(1'b1, 32'd5, 32'd7, 32'd0);
      waitDone32("w32_err", 2, 64'd0, 1'b1);
      applyStimulus32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      waitDone32("w32_max", W32 + 2, 64'hFFFF_FFFE_0000_0001, 1'b0);

      // Random 32-bit modular operations with legal operands.
      for (int i = 0; i < 20; i++) begin
         wn = $urandom | 32'h1;
         if (i % 4 == 0) wn = wn | 32'h8000_0000;
         wa = $urandom % wn;
         wb = $urandom % wn;
         model(1'b1, 64'(wa), 64'(wb), 64'(wn), ec, ee);
         applyStimulus32(1'b1, wa, wb, wn);
         waitDone32($sformatf("rnd32_%0d", i), W32 + 2, ec, ee);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rsa_core_modmult.md
RSA_CORE_MODMULT -- requirements
Module: rsa_core_modmult

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width W; legal range 2..64.
REQ-002 SHALL have parameter CLK_EDGE, default 1: 1 = rising edge of mmul_clk, 0 = falling edge.
REQ-003 SHALL have parameter START, default 1: the mmul_start level that requests an operation.
REQ-004 SHALL have port mmul_clk, input, 1: the single clock.
REQ-005 SHALL have port mmul_rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port mmul_start, input, 1: operation request, sampled in IDLE only.
REQ-007 SHALL have port mmul_mode, input, 1: 0 = plain product a*b, 1 = modular product (a*b) mod n.
REQ-008 SHALL have ports mmul_a, mmul_b, mmul_n, input, W each: multiplicand, multiplier and modulus.
REQ-009 SHALL have port mmul_busy, output, 1: an operation is in progress.
REQ-010 SHALL have port mmul_done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port mmul_err, output, 1: the last modular operation had illegal operands.
REQ-012 SHALL have port mmul_c, output, 2W: the result, held until the next completion.

Function
REQ-013 SHALL implement the FSM states IDLE, CHECK, RUN and DONE, with any other encoding returning to IDLE.
REQ-014 IDLE with mmul_start==START SHALL latch a, b, n and mode, set busy, clear the accumulator and counter, and go to CHECK.
REQ-015 CHECK with mode=1 and (n==0, a>=n or b>=n) SHALL go to DONE with the error flag set; otherwise it SHALL go to RUN.
REQ-016 RUN SHALL do one MSB-first bit of b per cycle for exactly W cycles, using counter 0..W-1, then go to DONE.
REQ-017 In mode 0 each RUN cycle SHALL compute P <= 2P + (b_i ? A : 0) at 2W width, with no overflow possible.
REQ-018 In mode 1 each RUN cycle SHALL compute T = 2P + (b_i ? A : 0), then subtract N up to twice so that 0 <= P < N; internal width SHALL be W+2.
REQ-019 DONE SHALL load mmul_c and mmul_err, pulse mmul_done for exactly one cycle, clear mmul_busy and go to IDLE.
REQ-020 In mode 1 mmul_c SHALL be zero-extended; on error mmul_c SHALL be 0.
REQ-021 Latency: with start sampled at active edge 0, mmul_done SHALL be high after edge W+2 (error case: after edge 2).
REQ-022 mmul_start while busy SHALL be ignored, and operand changes while busy SHALL not affect the result.
REQ-023 A start held during the mmul_done cycle SHALL be accepted, giving back-to-back operations.
REQ-024 mmul_err SHALL stay valid until the next completion and SHALL always be 0 for mode 0.

Reset
REQ-025 While mmul_rst=0, state SHALL be IDLE and busy, done, err, mmul_c, the accumulator, the counter and the latched operands SHALL all be 0, without waiting for a clock edge.
REQ-026 Reset mid-operation SHALL abort with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-027 A shared package rsa_pkg SHALL hold the FSM state encodings and a ceil-log2 function for sizing the counter.
REQ-028 One sub-module, rsa_modmult_step, SHALL hold the combinational iteration (double, add, conditional double-subtract), with a mode input.
REQ-029 All outputs SHALL be driven directly from flops.

Verification (W=8)
REQ-030 mode 0, a=0xFF, b=0xFF -> mmul_c=0xFE01, err=0, done exactly 10 edges after start, busy high until then.
REQ-031 mode 1, a=0x35, b=0x7A, n=0xC5 -> mmul_c=0x00A2; a=0xFE, b=0xFE, n=0xFF -> mmul_c=0x0001; b=0x00 -> mmul_c=0.
REQ-032 mode 1, n=0x00 or a=0xC5 with n=0xC5 -> err=1, mmul_c=0, done 2 edges after start; then mode 0, a=2, b=3 -> mmul_c=6, err=0.
REQ-033 Start re-asserted and operands changed at cycles 1..9 -> no restart; result is from the first operands; start held during done -> second result follows 10 edges later.
REQ-034 Reset asserted at RUN cycle 4 -> outputs 0 immediately, no done pulse; the next operation is correct.
REQ-035 Both CLK_EDGE values, and random mode-1 operands for W=8 and W=32 checked against a reference model (a*b)%n -> all match.
